// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 max-pool over two Layer-0 kernels, writing pooled maps to L1K0/L1K1
// and the kernel-interleaved flatten vector to L2F through the shared result-memory port.
module maxpool_flatten #(
  parameter int DW    = 20,
  parameter int AW    = 12,
  parameter int IMG_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int CB = $clog2(IMG_W / 2);
  localparam int PB = 2 * CB;
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L2F  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_LAST, S_WR_L1, S_WR_L2, S_DONE
  } state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_idx, w_idx;
  logic [PB-1:0] r_p, w_p;
  logic          r_k, w_k;
  logic [DW-1:0] r_max, w_max;
  logic          w_greater;

  logic          r_busy, r_done, r_crd, r_cwr;
  logic [AW-1:0] r_caddr_rd, r_caddr_wr;
  logic [DW-1:0] r_cdata_wr;
  logic [2:0]    r_csel;
  logic          w_busy, w_done, w_crd, w_cwr;
  logic [AW-1:0] w_caddr_rd, w_caddr_wr;
  logic [DW-1:0] w_cdata_wr;
  logic [2:0]    w_csel;

  assign w_greater = $signed(cdata_rd) > $signed(r_max);

  // Outputs are decoded from the next-state values and then registered, so each
  // registered output lines up with the state it belongs to.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_p     = r_p;
    w_k     = r_k;
    w_max   = r_max;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_RD;
          w_idx   = '0;
          w_p     = '0;
          w_k     = 1'b0;
        end
      end
      S_RD: begin
        // cdata_rd here belongs to the address issued in the previous RD cycle
        if (r_idx != 2'd0 && (r_idx == 2'd1 || w_greater)) w_max = cdata_rd;
        w_idx = r_idx + 2'd1;
        if (r_idx == 2'd3) w_state = S_RD_LAST;
      end
      S_RD_LAST: begin
        if (w_greater) w_max = cdata_rd;
        w_state = S_WR_L1;
      end
      S_WR_L1: w_state = S_WR_L2;
      S_WR_L2: begin
        if (!r_k) begin
          w_k     = 1'b1;
          w_state = S_RD;
        end else if (r_p != '1) begin
          w_p     = r_p + 1'b1;
          w_k     = 1'b0;
          w_state = S_RD;
        end else begin
          w_state = S_DONE;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_crd      = 1'b0;
    w_cwr      = 1'b0;
    w_caddr_rd = '0;
    w_caddr_wr = '0;
    w_cdata_wr = '0;
    w_csel     = SEL_NONE;
    case (w_state)
      S_RD: begin
        w_busy     = 1'b1;
        w_crd      = 1'b1;
        w_caddr_rd = AW'({w_p[PB-1:CB], w_idx[1], w_p[CB-1:0], w_idx[0]});
        w_csel     = SEL_L0K0 + {2'b00, w_k};
      end
      S_RD_LAST: begin
        w_busy = 1'b1;
        w_csel = SEL_L0K0 + {2'b00, w_k};
      end
      S_WR_L1: begin
        w_busy     = 1'b1;
        w_cwr      = 1'b1;
        w_caddr_wr = AW'(w_p);
        w_cdata_wr = w_max;
        w_csel     = SEL_L1K0 + {2'b00, w_k};
      end
      S_WR_L2: begin
        w_busy     = 1'b1;
        w_cwr      = 1'b1;
        w_caddr_wr = AW'({w_p, w_k});
        w_cdata_wr = w_max;
        w_csel     = SEL_L2F;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_p        <= '0;
      r_k        <= 1'b0;
      r_max      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_csel     <= SEL_NONE;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_p        <= w_p;
      r_k        <= w_k;
      r_max      <= w_max;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_crd      <= w_crd;
      r_cwr      <= w_cwr;
      r_caddr_rd <= w_caddr_rd;
      r_caddr_wr <= w_caddr_wr;
      r_cdata_wr <= w_cdata_wr;
      r_csel     <= w_csel;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign crd      = r_crd;
  assign cwr      = r_cwr;
  assign caddr_rd = r_caddr_rd;
  assign caddr_wr = r_caddr_wr;
  assign cdata_wr = r_cdata_wr;
  assign csel     = r_csel;

endmodule
